// File: rtl/gpu2d_pkg.sv
// Shared 2D engine definitions: FSM encoding, step directions and default widths.
// Used by the line rasteriser and its octant setup helper.
package gpu2d_pkg;
  localparam int DEF_COORD_W = 8;
  localparam int DEF_COLOR_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  // Direction flag for the walk: POS steps +1, NEG steps -1.
  localparam logic STEP_POS = 1'b0;
  localparam logic STEP_NEG = 1'b1;
endpackage

// File: rtl/line_octant_setup.sv
// Combinational Bresenham setup: |dx|, -|dy|, step directions and initial error.
// Zero latency; the caller registers the results in its SETUP cycle.
module line_octant_setup
  import gpu2d_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W
) (
  input  logic [COORD_W-1:0]        x0,
  input  logic [COORD_W-1:0]        y0,
  input  logic [COORD_W-1:0]        x1,
  input  logic [COORD_W-1:0]        y1,
  output logic signed [COORD_W+1:0] dx,
  output logic signed [COORD_W+1:0] dy,
  output logic signed [COORD_W+1:0] err,
  output logic                      sx,
  output logic                      sy
);
  logic [COORD_W-1:0] adx;
  logic [COORD_W-1:0] ady;

  always_comb begin
    if (x1 >= x0) begin
      sx  = STEP_POS;
      adx = x1 - x0;
    end else begin
      sx  = STEP_NEG;
      adx = x0 - x1;
    end
    if (y1 >= y0) begin
      sy  = STEP_POS;
      ady = y1 - y0;
    end else begin
      sy  = STEP_NEG;
      ady = y0 - y1;
    end
    // Two guard bits keep dx+dy and the doubled error free of overflow.
    dx  = signed'({2'b00, adx});
    dy  = -signed'({2'b00, ady});
    err = dx + dy;
  end
endmodule

// File: rtl/line_raster_stream.sv
// All-octant Bresenham line rasteriser with dash pattern, end-pixel omission and abort.
// First pixel two cycles after accept; a pixel is held until pix_ready, 1 pixel/cycle unstalled.
module line_raster_stream
  import gpu2d_pkg::*;
#(
  parameter int COORD_W   = DEF_COORD_W,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int PATTERN_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [COORD_W-1:0]   x0,
  input  logic [COORD_W-1:0]   y0,
  input  logic [COORD_W-1:0]   x1,
  input  logic [COORD_W-1:0]   y1,
  input  logic [COLOR_W-1:0]   color,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic                 omit_last,
  input  logic                 abort,
  output logic                 pix_valid,
  input  logic                 pix_ready,
  output logic [COORD_W-1:0]   px,
  output logic [COORD_W-1:0]   py,
  output logic [COLOR_W-1:0]   pix_color,
  output logic                 busy,
  output logic                 done,
  output logic [COORD_W:0]     pix_count
);
  localparam int SW = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
  localparam int EW = COORD_W + 2;

  state_t state, state_nxt;

  logic [COORD_W-1:0]   x0_q, y0_q, x1_q, y1_q;
  logic [COLOR_W-1:0]   color_q;
  logic [PATTERN_W-1:0] pattern_q;
  logic                 omit_q;

  logic signed [EW-1:0] dx_q, dy_q, err_q;
  logic                 sx_q, sy_q;
  logic [COORD_W-1:0]   cur_x, cur_y;
  logic [SW-1:0]        step_q;

  logic signed [EW-1:0] su_dx, su_dy, su_err;
  logic                 su_sx, su_sy;

  logic                 accept, advance, finish;
  logic                 at_end, emit;
  logic signed [EW:0]   e2, dx_e, dy_e;
  logic signed [EW-1:0] err_nxt;
  logic [COORD_W-1:0]   cur_x_nxt, cur_y_nxt;
  logic [SW-1:0]        step_nxt;

  line_octant_setup #(.COORD_W(COORD_W)) u_setup (
    .x0  (x0_q),
    .y0  (y0_q),
    .x1  (x1_q),
    .y1  (y1_q),
    .dx  (su_dx),
    .dy  (su_dy),
    .err (su_err),
    .sx  (su_sx),
    .sy  (su_sy)
  );

  assign at_end    = (cur_x == x1_q) && (cur_y == y1_q);
  assign emit      = pattern_q[step_q] && !(omit_q && at_end);
  assign px        = cur_x;
  assign py        = cur_y;
  assign pix_color = color_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    pix_valid = 1'b0;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid && !abort) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_nxt = abort ? ST_IDLE : ST_DRAW;
      end
      ST_DRAW: begin
        pix_valid = emit;
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (!emit || pix_ready) begin
          advance = 1'b1;
          if (at_end) begin
            finish    = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // One Bresenham step; both axes move when the doubled error satisfies both tests.
  always_comb begin
    e2        = signed'({err_q, 1'b0});
    dx_e      = signed'({dx_q[EW-1], dx_q});
    dy_e      = signed'({dy_q[EW-1], dy_q});
    err_nxt   = err_q;
    cur_x_nxt = cur_x;
    cur_y_nxt = cur_y;
    if (e2 >= dy_e) begin
      cur_x_nxt = (sx_q == STEP_NEG) ? cur_x - 1'b1 : cur_x + 1'b1;
      err_nxt   = err_nxt + dy_q;
    end
    if (e2 <= dx_e) begin
      cur_y_nxt = (sy_q == STEP_NEG) ? cur_y - 1'b1 : cur_y + 1'b1;
      err_nxt   = err_nxt + dx_q;
    end
    step_nxt = (step_q == SW'(PATTERN_W - 1)) ? '0 : step_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x0_q      <= '0;
      y0_q      <= '0;
      x1_q      <= '0;
      y1_q      <= '0;
      color_q   <= '0;
      pattern_q <= '0;
      omit_q    <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      err_q     <= '0;
      sx_q      <= STEP_POS;
      sy_q      <= STEP_POS;
      cur_x     <= '0;
      cur_y     <= '0;
      step_q    <= '0;
      done      <= 1'b0;
      pix_count <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        x0_q      <= x0;
        y0_q      <= y0;
        x1_q      <= x1;
        y1_q      <= y1;
        color_q   <= color;
        pattern_q <= pattern;
        omit_q    <= omit_last;
        pix_count <= '0;
      end
      if (state == ST_SETUP) begin
        dx_q   <= su_dx;
        dy_q   <= su_dy;
        err_q  <= su_err;
        sx_q   <= su_sx;
        sy_q   <= su_sy;
        cur_x  <= x0_q;
        cur_y  <= y0_q;
        step_q <= '0;
      end
      if (advance) begin
        if (emit) pix_count <= pix_count + 1'b1;
        if (!at_end) begin
          err_q  <= err_nxt;
          cur_x  <= cur_x_nxt;
          cur_y  <= cur_y_nxt;
          step_q <= step_nxt;
        end
      end
    end
  end
endmodule

// File: tb/tb_line_raster_stream.sv
// Directed bench for line_raster_stream: pixel sequences, timing, stalls, pattern, abort, reset.
module tb_line_raster_stream;
  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  x0, y0, x1, y1;
  logic [23:0] color;
  logic [7:0]  pattern;
  logic        omit_last;
  logic        abort;
  logic        pix_valid;
  logic        pix_ready;
  logic [7:0]  px, py;
  logic [23:0] pix_color;
  logic        busy;
  logic        done;
  logic [8:0]  pix_count;

  int checks = 0;
  int errors = 0;

  // Capture of the last line, filled by collect()
  int         n_pix;
  logic [7:0] cap_x [16];
  logic [7:0] cap_y [16];
  int         cap_cyc [16];
  int         done_cyc;
  int         done_cnt;
  int         stall_bad;
  int         valid_cnt;

  line_raster_stream dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .x0        (x0),
    .y0        (y0),
    .x1        (x1),
    .y1        (y1),
    .color     (color),
    .pattern   (pattern),
    .omit_last (omit_last),
    .abort     (abort),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .px        (px),
    .py        (py),
    .pix_color (pix_color),
    .busy      (busy),
    .done      (done),
    .pix_count (pix_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Presents one command during the current cycle; returns #1 into the SETUP cycle.
  task automatic send_cmd(input logic [7:0] ax0, input logic [7:0] ay0, input logic [7:0] ax1,
                          input logic [7:0] ay1, input logic [7:0] pat, input logic om,
                          input logic [23:0] col);
    x0 = ax0; y0 = ay0; x1 = ax1; y1 = ay1;
    pattern = pat; omit_last = om; color = col;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Cycle index c=1 is the SETUP cycle. mode 0: ready always high; mode 1: ready 1,0,1,0...
  task automatic collect(input int max_c, input int mode);
    logic [7:0] hx, hy;
    logic       held;
    n_pix = 0; done_cyc = -1; done_cnt = 0; stall_bad = 0; valid_cnt = 0;
    held = 1'b0; hx = '0; hy = '0;
    for (int c = 1; c <= max_c; c++) begin
      pix_ready = (mode == 0) ? 1'b1 : c[0];
      #1;
      if (held && (!pix_valid || px !== hx || py !== hy)) stall_bad++;
      held = 1'b0;
      if (pix_valid) begin
        valid_cnt++;
        if (pix_ready) begin
          if (n_pix < 16) begin
            cap_x[n_pix] = px; cap_y[n_pix] = py; cap_cyc[n_pix] = c;
          end
          n_pix++;
        end else begin
          held = 1'b1; hx = px; hy = py;
        end
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(posedge clk); #1;
    end
    pix_ready = 1'b1;
  endtask

  task automatic test_reset;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (px !== 8'd0 || py !== 8'd0) begin errors++; $display("FAIL reset_pxpy got (%0d,%0d) want (0,0)", px, py); end
    checks++; if (pix_color !== 24'd0) begin errors++; $display("FAIL reset_color got %h want 0", pix_color); end
    checks++; if (pix_count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d want 0", pix_count); end
  endtask

  task automatic test_shallow;
    logic [7:0] ex [6];
    logic [7:0] ey [6];
    ex = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    ey = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd2, 8'd2};
    send_cmd(8'd0, 8'd0, 8'd5, 8'd2, 8'hFF, 1'b0, 24'hA1B2C3);
    collect(40, 0);
    checks++; if (n_pix != 6) begin errors++; $display("FAIL shallow_npix got %0d want 6", n_pix); end
    for (int i = 0; i < 6 && i < n_pix; i++) begin
      checks++;
      if (cap_x[i] !== ex[i] || cap_y[i] !== ey[i]) begin
        errors++; $display("FAIL shallow_pix%0d got (%0d,%0d) want (%0d,%0d)", i, cap_x[i], cap_y[i], ex[i], ey[i]);
      end
    end
    checks++; if (n_pix < 1 || cap_cyc[0] != 2) begin errors++; $display("FAIL shallow_latency got %0d want 2", cap_cyc[0]); end
    checks++; if (done_cyc != 8 || done_cnt != 1) begin errors++; $display("FAIL shallow_done got cyc %0d cnt %0d want cyc 8 cnt 1", done_cyc, done_cnt); end
    checks++; if (pix_count !== 9'd6) begin errors++; $display("FAIL shallow_count got %0d want 6", pix_count); end
    checks++; if (pix_color !== 24'hA1B2C3) begin errors++; $display("FAIL shallow_color got %h want a1b2c3", pix_color); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL shallow_idle got busy %b rdy %b want 0 1", busy, cmd_ready); end
  endtask

  task automatic test_steep_neg;
    logic [7:0] ex [6];
    logic [7:0] ey [6];
    ex = '{8'd5, 8'd4, 8'd4, 8'd3, 8'd3, 8'd2};
    ey = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    send_cmd(8'd5, 8'd5, 8'd2, 8'd0, 8'hFF, 1'b0, 24'h00FF00);
    collect(40, 0);
    checks++; if (n_pix != 6) begin errors++; $display("FAIL steep_npix got %0d want 6", n_pix); end
    for (int i = 0; i < 6 && i < n_pix; i++) begin
      checks++;
      if (cap_x[i] !== ex[i] || cap_y[i] !== ey[i]) begin
        errors++; $display("FAIL steep_pix%0d got (%0d,%0d) want (%0d,%0d)", i, cap_x[i], cap_y[i], ex[i], ey[i]);
      end
    end
  endtask

  task automatic test_pattern;
    send_cmd(8'd0, 8'd0, 8'd7, 8'd0, 8'h55, 1'b0, 24'h123456);
    collect(40, 0);
    checks++; if (n_pix != 4) begin errors++; $display("FAIL pattern_npix got %0d want 4", n_pix); end
    for (int i = 0; i < 4 && i < n_pix; i++) begin
      checks++;
      if (cap_x[i] !== 8'(2 * i) || cap_y[i] !== 8'd0) begin
        errors++; $display("FAIL pattern_pix%0d got (%0d,%0d) want (%0d,0)", i, cap_x[i], cap_y[i], 2 * i);
      end
    end
    checks++; if (pix_count !== 9'd4) begin errors++; $display("FAIL pattern_count got %0d want 4", pix_count); end
    checks++; if (done_cyc != 10) begin errors++; $display("FAIL pattern_done got %0d want 10", done_cyc); end
  endtask

  task automatic test_stall;
    send_cmd(8'd0, 8'd0, 8'd3, 8'd3, 8'hFF, 1'b0, 24'hABCDEF);
    collect(40, 1);
    checks++; if (n_pix != 4) begin errors++; $display("FAIL stall_npix got %0d want 4", n_pix); end
    for (int i = 0; i < 4 && i < n_pix; i++) begin
      checks++;
      if (cap_x[i] !== 8'(i) || cap_y[i] !== 8'(i)) begin
        errors++; $display("FAIL stall_pix%0d got (%0d,%0d) want (%0d,%0d)", i, cap_x[i], cap_y[i], i, i);
      end
    end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL stall_stable got %0d changes want 0", stall_bad); end
    checks++; if (pix_count !== 9'd4 || done_cnt != 1) begin errors++; $display("FAIL stall_end got count %0d done %0d want 4 1", pix_count, done_cnt); end
  endtask

  task automatic test_degenerate;
    send_cmd(8'd4, 8'd4, 8'd4, 8'd4, 8'hFF, 1'b1, 24'h111111);
    collect(20, 0);
    checks++; if (valid_cnt != 0) begin errors++; $display("FAIL degen_omit_valid got %0d want 0", valid_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL degen_omit_done got %0d want 1", done_cnt); end
    checks++; if (pix_count !== 9'd0) begin errors++; $display("FAIL degen_omit_count got %0d want 0", pix_count); end
    send_cmd(8'd4, 8'd4, 8'd4, 8'd4, 8'hFF, 1'b0, 24'h222222);
    collect(20, 0);
    checks++; if (n_pix != 1 || cap_x[0] !== 8'd4 || cap_y[0] !== 8'd4) begin
      errors++; $display("FAIL degen_pix got n %0d (%0d,%0d) want 1 (4,4)", n_pix, cap_x[0], cap_y[0]);
    end
    checks++; if (done_cyc != 3 || pix_count !== 9'd1) begin errors++; $display("FAIL degen_done got cyc %0d count %0d want 3 1", done_cyc, pix_count); end
  endtask

  task automatic test_abort;
    int  hs;
    int  dseen;
    logic got;
    send_cmd(8'd0, 8'd0, 8'd9, 8'd9, 8'hFF, 1'b0, 24'h0000FF);
    hs = 0; got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      pix_ready = 1'b1;
      #1;
      if (pix_valid) hs++;
      if (hs == 3) got = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (!got) begin errors++; $display("FAIL abort_timeout got %0d handshakes want 3", hs); end
    abort = 1'b1; pix_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || pix_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL abort_idle got busy %b valid %b rdy %b want 0 0 1", busy, pix_valid, cmd_ready);
    end
    checks++; if (pix_count !== 9'd3) begin errors++; $display("FAIL abort_count got %0d want 3", pix_count); end
    dseen = 0;
    for (int c = 0; c < 4; c++) begin
      if (done) dseen++;
      @(posedge clk); #1;
    end
    checks++; if (dseen != 0) begin errors++; $display("FAIL abort_done got %0d pulses want 0", dseen); end

    // A command presented together with abort in IDLE is refused
    abort = 1'b1;
    send_cmd(8'd1, 8'd1, 8'd2, 8'd2, 8'hFF, 1'b0, 24'h333333);
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_blocks_accept got busy %b want 0", busy); end
  endtask

  task automatic test_reset_midline;
    int dseen;
    send_cmd(8'd0, 8'd0, 8'd9, 8'd9, 8'hFF, 1'b0, 24'hFEDCBA);
    pix_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
    end
    checks++; if (busy !== 1'b1 || px === 8'd0) begin errors++; $display("FAIL midline_running got busy %b px %0d want 1 nonzero", busy, px); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || pix_valid !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL midline_ctrl got busy %b valid %b rdy %b done %b want 0 0 1 0", busy, pix_valid, cmd_ready, done);
    end
    checks++; if (px !== 8'd0 || py !== 8'd0 || pix_color !== 24'd0 || pix_count !== 9'd0) begin
      errors++; $display("FAIL midline_data got (%0d,%0d) col %h cnt %0d want (0,0) 0 0", px, py, pix_color, pix_count);
    end
    @(posedge clk); #3;
    reset_n = 1'b1;
    dseen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done || busy) dseen++;
    end
    checks++; if (dseen != 0) begin errors++; $display("FAIL midline_after got %0d active cycles want 0", dseen); end
  endtask

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    color = '0; pattern = '0; omit_last = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    #2 reset_n = 1'b1;
    @(posedge clk); #1;
    test_reset;
    test_shallow;
    test_steep_neg;
    test_pattern;
    test_stall;
    test_degenerate;
    test_abort;
    test_reset_midline;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
